ctrl_mc: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle control decoder. It sequences each instruction through fetch, execute and an optional memory-wait phase. It owns a req/ack handshake to data memory, a timeout error path, a sticky done/halt flag and a retired-instruction counter. It sits between instruction memory/PC and the datapath (RegFile, accumulator, LUT, ALU, data memory). Opcode constants come from package Definitions.

---
 rtl/ctrl_mc.sv | 256 +++++++++++++++++++++++++
 tb/tb_ctrl_mc.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_mc.sv
// Definitions holds the opcode map shared by the multi-cycle control unit and
// the datapath. ctrl_mc sequences each instruction through FETCH, EXEC and an
// optional MEM_WAIT. It also owns the memory handshake, the timeout error path,
// the sticky done/error flags and the retired-instruction counter.
package Definitions;
  localparam logic [4:0] OP_AND      = 5'd0;
  localparam logic [4:0] OP_ORR      = 5'd1;
  localparam logic [4:0] OP_XOR_B    = 5'd2;
  localparam logic [4:0] OP_XOR_G    = 5'd3;
  localparam logic [4:0] OP_ADD      = 5'd4;
  localparam logic [4:0] OP_SHL      = 5'd5;
  localparam logic [4:0] OP_SHR      = 5'd6;
  localparam logic [4:0] OP_CMP      = 5'd7;
  localparam logic [4:0] OP_CMP_LS   = 5'd8;
  localparam logic [4:0] OP_LDA      = 5'd9;
  localparam logic [4:0] OP_STA      = 5'd10;
  localparam logic [4:0] OP_SET_H    = 5'd11;
  localparam logic [4:0] OP_SET_L    = 5'd12;
  localparam logic [4:0] OP_LD_LUT_H = 5'd13;
  localparam logic [4:0] OP_LD_LUT_L = 5'd14;
  localparam logic [4:0] OP_JMP      = 5'd15;
  localparam logic [4:0] OP_BEQ      = 5'd16;
  localparam logic [4:0] OP_LDR      = 5'd17;
  localparam logic [4:0] OP_STR      = 5'd18;
  localparam logic [4:0] OP_HLT      = 5'd19;
endpackage

module ctrl_mc
  import Definitions::*;
#(
  parameter int IW     = 9,
  parameter int OPW    = 5,
  parameter int AW     = 8,
  parameter int MEM_TO = 15,
  parameter int CW     = 16
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Start,
  input  logic [IW-1:0]  Instruction,
  input  logic           Instr_Valid,
  input  logic [AW-1:0]  AccInput,
  input  logic           Mem_Ack,
  output logic           PC_Inc,
  output logic           PC_Jmp_Flag,
  output logic           PC_Beq_Flag,
  output logic           LUT_Read_En,
  output logic           LUT_Write_En,
  output logic           LUT_Load_Hi,
  output logic           Reg_Write_En,
  output logic [1:0]     Reg_Src,
  output logic           Acc_Write_En,
  output logic [1:0]     Acc_Src,
  output logic           Acc_Load_Hi,
  output logic           Mem_Req,
  output logic           Mem_Write_En,
  output logic [OPW-1:0] ALU_Opcode,
  output logic           Ack,
  output logic           Busy,
  output logic           Err,
  output logic [CW-1:0]  Retired
);

  localparam int TW = $clog2(MEM_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [IW-1:0]    ir;
  logic [TW-1:0]    to_cnt;
  logic [OPW-1:0]   opcode;
  logic             all_ones;
  logic             is_halt;
  logic             is_mem;
  logic             is_str;
  logic             is_ldr;
  logic             legal;
  logic             acc_one;
  logic [CW-1:0]    retired_next;

  assign opcode       = ir[IW-1 -: OPW];
  assign all_ones     = (ir == {IW{1'b1}});
  assign is_halt      = all_ones || (opcode == OP_HLT);
  assign is_ldr       = (opcode == OP_LDR);
  assign is_str       = (opcode == OP_STR);
  assign is_mem       = is_ldr || is_str;
  assign acc_one      = (AccInput == AW'(1));
  assign retired_next = (Retired == {CW{1'b1}}) ? Retired : Retired + CW'(1);
  assign Busy         = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM_WAIT);

  // Flag which opcodes the machine knows; anything else in EXEC traps to ERR.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_AND, OP_ORR, OP_XOR_B, OP_XOR_G, OP_ADD, OP_SHL, OP_SHR,
      OP_CMP, OP_CMP_LS, OP_LDA, OP_STA, OP_SET_H, OP_SET_L,
      OP_LD_LUT_H, OP_LD_LUT_L, OP_JMP, OP_BEQ, OP_LDR, OP_STR,
      OP_HLT:  legal = 1'b1;
      default: legal = all_ones;
    endcase
  end

  // Sequencer: state, instruction register, memory timeout, retire count and sticky flags.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      ir      <= '0;
      to_cnt  <= '0;
      Retired <= '0;
      Ack     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state   <= S_FETCH;
            Retired <= '0;
          end
        end
        S_FETCH: begin
          if (Instr_Valid) begin
            ir    <= Instruction;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          to_cnt <= '0;
          if (is_halt) begin
            state   <= S_DONE;
            Ack     <= 1'b1;
            Retired <= retired_next;
          end else if (!legal) begin
            state <= S_ERR;
            Err   <= 1'b1;
          end else if (is_mem) begin
            state <= S_MEM_WAIT;
          end else begin
            state   <= S_FETCH;
            Retired <= retired_next;
          end
        end
        S_MEM_WAIT: begin
          if (Mem_Ack) begin
            state   <= S_FETCH;
            to_cnt  <= '0;
            Retired <= retired_next;
          end else if (to_cnt == TW'(MEM_TO - 1)) begin
            state  <= S_ERR;
            Err    <= 1'b1;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_DONE: begin
          if (Start) begin
            state   <= S_FETCH;
            Ack     <= 1'b0;
            Retired <= '0;
          end
        end
        S_ERR: begin
          if (Start) begin
            state <= S_FETCH;
            Err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath controls decoded from IR; only EXEC and MEM_WAIT drive anything. CMP also steers the ALU.
  always_comb begin
    PC_Inc       = 1'b0;
    PC_Jmp_Flag  = 1'b0;
    PC_Beq_Flag  = 1'b0;
    LUT_Read_En  = 1'b0;
    LUT_Write_En = 1'b0;
    LUT_Load_Hi  = 1'b0;
    Reg_Write_En = 1'b0;
    Reg_Src      = 2'd0;
    Acc_Write_En = 1'b0;
    Acc_Src      = 2'd0;
    Acc_Load_Hi  = 1'b0;
    Mem_Req      = 1'b0;
    Mem_Write_En = 1'b0;
    ALU_Opcode   = '0;
    if (state == S_EXEC && !all_ones) begin
      case (opcode)
        OP_AND, OP_ORR, OP_XOR_B, OP_XOR_G, OP_ADD, OP_SHL, OP_SHR: begin
          ALU_Opcode   = opcode;
          Reg_Write_En = 1'b1;
          PC_Inc       = 1'b1;
        end
        OP_CMP, OP_CMP_LS: begin
          ALU_Opcode   = opcode;
          Acc_Write_En = 1'b1;
          PC_Inc       = 1'b1;
        end
        OP_LDA: begin
          Acc_Write_En = 1'b1;
          Acc_Src      = 2'd1;
          PC_Inc       = 1'b1;
        end
        OP_STA: begin
          Reg_Write_En = 1'b1;
          Reg_Src      = 2'd2;
          PC_Inc       = 1'b1;
        end
        OP_SET_H, OP_SET_L: begin
          Acc_Write_En = 1'b1;
          Acc_Src      = 2'd2;
          Acc_Load_Hi  = (opcode == OP_SET_H);
          PC_Inc       = 1'b1;
        end
        OP_LD_LUT_H, OP_LD_LUT_L: begin
          LUT_Write_En = 1'b1;
          LUT_Load_Hi  = (opcode == OP_LD_LUT_H);
          PC_Inc       = 1'b1;
        end
        OP_JMP: begin
          LUT_Read_En = 1'b1;
          PC_Jmp_Flag = 1'b1;
        end
        OP_BEQ: begin
          LUT_Read_En = 1'b1;
          PC_Beq_Flag = acc_one;
          PC_Inc      = !acc_one;
        end
        OP_LDR: Mem_Req = 1'b1;
        OP_STR: begin
          Mem_Req      = 1'b1;
          Mem_Write_En = 1'b1;
        end
        default: ALU_Opcode = '0;
      endcase
    end else if (state == S_MEM_WAIT) begin
      Mem_Req      = 1'b1;
      Mem_Write_En = is_str;
      if (Mem_Ack) begin
        PC_Inc       = 1'b1;
        Reg_Write_En = is_ldr;
        Reg_Src      = is_ldr ? 2'd1 : 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// Scoreboarded bench for ctrl_mc: stimulus tasks push the expected per-cycle
// response derived from each instruction's lifecycle, and a monitor pops and compares.
module tb_ctrl_mc;
  import Definitions::*;

  localparam int IW     = 9;
  localparam int OPW    = 5;
  localparam int AW     = 8;
  localparam int MEM_TO = 15;
  localparam int CW     = 4;
  localparam int RMAX   = (1 << CW) - 1;

  logic           Clk = 1'b0;
  logic           Reset_n = 1'b0;
  logic           Start = 1'b0;
  logic [IW-1:0]  Instruction = '0;
  logic           Instr_Valid = 1'b0;
  logic [AW-1:0]  AccInput = '0;
  logic           Mem_Ack = 1'b0;
  logic           PC_Inc, PC_Jmp_Flag, PC_Beq_Flag;
  logic           LUT_Read_En, LUT_Write_En, LUT_Load_Hi;
  logic           Reg_Write_En, Acc_Write_En, Acc_Load_Hi;
  logic [1:0]     Reg_Src, Acc_Src;
  logic           Mem_Req, Mem_Write_En;
  logic [OPW-1:0] ALU_Opcode;
  logic           Ack, Busy, Err;
  logic [CW-1:0]  Retired;

  ctrl_mc #(.IW(IW), .OPW(OPW), .AW(AW), .MEM_TO(MEM_TO), .CW(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instruction(Instruction),
    .Instr_Valid(Instr_Valid), .AccInput(AccInput), .Mem_Ack(Mem_Ack),
    .PC_Inc(PC_Inc), .PC_Jmp_Flag(PC_Jmp_Flag), .PC_Beq_Flag(PC_Beq_Flag),
    .LUT_Read_En(LUT_Read_En), .LUT_Write_En(LUT_Write_En), .LUT_Load_Hi(LUT_Load_Hi),
    .Reg_Write_En(Reg_Write_En), .Reg_Src(Reg_Src), .Acc_Write_En(Acc_Write_En),
    .Acc_Src(Acc_Src), .Acc_Load_Hi(Acc_Load_Hi), .Mem_Req(Mem_Req),
    .Mem_Write_En(Mem_Write_En), .ALU_Opcode(ALU_Opcode), .Ack(Ack), .Busy(Busy),
    .Err(Err), .Retired(Retired)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic           pc_inc, pc_jmp, pc_beq, lut_rd, lut_wr, lut_hi, reg_we;
    logic [1:0]     reg_src;
    logic           acc_we;
    logic [1:0]     acc_src;
    logic           acc_hi, mem_req, mem_we;
    logic [OPW-1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic          ack, busy, err;
    logic [CW-1:0] retired;
  } stat_t;

  typedef struct {
    ctrl_t c;
    stat_t s;
    string nm;
  } exp_t;

  ctrl_t actCtrl;
  stat_t actStat;
  assign actCtrl = {PC_Inc, PC_Jmp_Flag, PC_Beq_Flag, LUT_Read_En, LUT_Write_En, LUT_Load_Hi,
                    Reg_Write_En, Reg_Src, Acc_Write_En, Acc_Src, Acc_Load_Hi, Mem_Req,
                    Mem_Write_En, ALU_Opcode};
  assign actStat = {Ack, Busy, Err, Retired};

  exp_t sb[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Abstract machine model: running or not, sticky flags, retire count.
  bit mBusy = 1'b0, mAck = 1'b0, mErr = 1'b0;
  int mRet = 0;

  // Next-cycle input values, applied by applyStimulus just after the clock edge.
  logic           dRstN = 1'b0, dStart = 1'b0, dValid = 1'b0, dMack = 1'b0;
  logic [IW-1:0]  dInstr = '0;
  logic [AW-1:0]  dAcc = '0;

  logic [OPW-1:0] nonMemOps [17] = '{OP_AND, OP_ORR, OP_XOR_B, OP_XOR_G, OP_ADD, OP_SHL,
                                     OP_SHR, OP_CMP, OP_CMP_LS, OP_LDA, OP_STA, OP_SET_H,
                                     OP_SET_L, OP_LD_LUT_H, OP_LD_LUT_L, OP_JMP, OP_BEQ};

  function automatic logic [IW-1:0] mk(input logic [OPW-1:0] op, input logic [IW-OPW-1:0] arg);
    return {op, arg};
  endfunction

  function automatic bit legalOp(input logic [OPW-1:0] op);
    return op inside {OP_AND, OP_ORR, OP_XOR_B, OP_XOR_G, OP_ADD, OP_SHL, OP_SHR, OP_CMP,
                      OP_CMP_LS, OP_LDA, OP_STA, OP_SET_H, OP_SET_L, OP_LD_LUT_H,
                      OP_LD_LUT_L, OP_JMP, OP_BEQ, OP_LDR, OP_STR, OP_HLT};
  endfunction

  // Controls the instruction must show during its EXEC cycle.
  function automatic ctrl_t decodeExp(input logic [IW-1:0] ins, input logic [AW-1:0] acc);
    ctrl_t          d;
    logic [OPW-1:0] op;
    d  = '0;
    op = ins[IW-1 -: OPW];
    if (ins == {IW{1'b1}}) return d;
    case (op)
      OP_AND, OP_ORR, OP_XOR_B, OP_XOR_G, OP_ADD, OP_SHL, OP_SHR: begin
        d.alu_op = op; d.reg_we = 1'b1; d.pc_inc = 1'b1;
      end
      OP_CMP, OP_CMP_LS: begin d.alu_op = op; d.acc_we = 1'b1; d.pc_inc = 1'b1; end
      OP_LDA:      begin d.acc_we = 1'b1; d.acc_src = 2'd1; d.pc_inc = 1'b1; end
      OP_STA:      begin d.reg_we = 1'b1; d.reg_src = 2'd2; d.pc_inc = 1'b1; end
      OP_SET_H:    begin d.acc_we = 1'b1; d.acc_src = 2'd2; d.acc_hi = 1'b1; d.pc_inc = 1'b1; end
      OP_SET_L:    begin d.acc_we = 1'b1; d.acc_src = 2'd2; d.pc_inc = 1'b1; end
      OP_LD_LUT_H: begin d.lut_wr = 1'b1; d.lut_hi = 1'b1; d.pc_inc = 1'b1; end
      OP_LD_LUT_L: begin d.lut_wr = 1'b1; d.pc_inc = 1'b1; end
      OP_JMP:      begin d.lut_rd = 1'b1; d.pc_jmp = 1'b1; end
      OP_BEQ: begin
        d.lut_rd = 1'b1;
        if (acc == 8'h01) d.pc_beq = 1'b1;
        else d.pc_inc = 1'b1;
      end
      OP_LDR:      d.mem_req = 1'b1;
      OP_STR:      begin d.mem_req = 1'b1; d.mem_we = 1'b1; end
      default:     d = '0;
    endcase
    return d;
  endfunction

  task automatic bumpRetired();
    mRet = (mRet < RMAX) ? mRet + 1 : RMAX;
  endtask

  task automatic rnd();
    dInstr = IW'($urandom);
    dValid = 1'($urandom);
    dAcc   = AW'($urandom);
    dMack  = 1'($urandom);
    dStart = 1'b0;
  endtask

  // Apply the prepared inputs for one cycle and queue what the DUT must show in it.
  task automatic applyStimulus(input ctrl_t c, input bit chk, input string nm);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset_n = dRstN; Start = dStart; Instruction = dInstr;
    Instr_Valid = dValid; AccInput = dAcc; Mem_Ack = dMack;
    if (chk) begin
      e.c = c;
      e.s.ack = mAck; e.s.busy = mBusy; e.s.err = mErr; e.s.retired = CW'(mRet);
      e.nm = nm;
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    nChecks++;
    if (actCtrl !== e.c) begin
      nFails++;
      $display("[TB] FAIL %s ctrl: got %h, expected %h", e.nm, actCtrl, e.c);
    end
    nChecks++;
    if (actStat !== e.s) begin
      nFails++;
      $display("[TB] FAIL %s status{ack,busy,err,retired}: got %h, expected %h", e.nm, actStat, e.s);
    end
  endtask

  // Monitor: compare each queued expectation against the outputs mid-cycle.
  initial begin : monitor
    forever begin
      @(negedge Clk);
      if (sb.size() != 0) checkOutput(sb.pop_front());
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      rnd();
      applyStimulus('0, 1'b1, "idle_hold");
    end
  endtask

  task automatic startRun();
    rnd();
    dStart = 1'b1;
    applyStimulus('0, 1'b1, "start");
    if (!mErr) mRet = 0;
    mAck = 1'b0; mErr = 1'b0; mBusy = 1'b1;
  endtask

  task automatic ensureRunning();
    if (!mBusy) begin
      idleCycles(1);
      startRun();
    end
  endtask

  // One instruction: gap stalled fetch cycles, then fetch, exec and any memory wait.
  task automatic runInstr(input logic [IW-1:0] ins, input int gap, input int ackAfter,
                          input logic [AW-1:0] acc, input int rstAt);
    ctrl_t          d;
    logic [OPW-1:0] op;
    op = ins[IW-1 -: OPW];
    repeat (gap) begin
      rnd(); dValid = 1'b0; dStart = 1'($urandom);
      applyStimulus('0, 1'b1, "fetch_stall");
    end
    rnd(); dValid = 1'b1; dInstr = ins; dStart = 1'($urandom);
    applyStimulus('0, 1'b1, "fetch");
    rnd(); dStart = 1'($urandom); dAcc = acc;
    applyStimulus(decodeExp(ins, acc), 1'b1, $sformatf("exec_%h_acc%h", ins, acc));
    if (ins == {IW{1'b1}} || op == OP_HLT) begin
      bumpRetired(); mAck = 1'b1; mBusy = 1'b0;
    end else if (!legalOp(op)) begin
      mErr = 1'b1; mBusy = 1'b0;
    end else if (op == OP_LDR || op == OP_STR) begin
      d = '0; d.mem_req = 1'b1; d.mem_we = (op == OP_STR);
      for (int i = 0; i < MEM_TO; i++) begin
        rnd(); dStart = 1'($urandom);
        if (i == rstAt) begin
          dRstN = 1'b0; dMack = 1'b0;
          applyStimulus(d, 1'b1, "mem_wait_reset");
          dRstN = 1'b1;
          mBusy = 1'b0; mAck = 1'b0; mErr = 1'b0; mRet = 0;
          return;
        end
        dMack = (i == ackAfter);
        if (i == ackAfter) begin
          d.pc_inc = 1'b1;
          if (op == OP_LDR) begin d.reg_we = 1'b1; d.reg_src = 2'd1; end
          applyStimulus(d, 1'b1, $sformatf("mem_ack_%h", ins));
          bumpRetired();
          return;
        end
        applyStimulus(d, 1'b1, $sformatf("mem_wait%0d_%h", i, ins));
      end
      mErr = 1'b1; mBusy = 1'b0;
    end else begin
      bumpRetired();
    end
  endtask

  initial begin : stimulus
    logic [IW-1:0] ins;
    int            ackAfter;

    dRstN = 1'b0;
    repeat (2) applyStimulus('0, 1'b0, "reset");
    dRstN = 1'b1;
    idleCycles(2);

    startRun();
    runInstr(mk(OP_ADD, 4'h3), 0, 0, 8'h00, -1);
    runInstr(mk(OP_HLT, 4'h0), 0, 0, 8'h00, -1);
    idleCycles(3);

    startRun();
    runInstr(mk(OP_BEQ, 4'h1), 0, 0, 8'h01, -1);
    runInstr(mk(OP_BEQ, 4'h1), 0, 0, 8'h02, -1);
    runInstr(mk(OP_JMP, 4'h2), 0, 0, 8'h01, -1);
    runInstr(mk(OP_LDR, 4'h4), 0, 2, 8'h00, -1);
    runInstr(mk(OP_STR, 4'h5), 0, 2, 8'h00, -1);
    runInstr(mk(OP_LDR, 4'h6), 5, 0, 8'h00, -1);
    runInstr(mk(OP_LDR, 4'h7), 0, -1, 8'h00, -1);
    idleCycles(2);
    startRun();
    runInstr(mk(OP_HLT, 4'h0), 0, 0, 8'h00, -1);

    idleCycles(1);
    startRun();
    for (int i = 0; i < 20; i++)
      runInstr(mk(nonMemOps[$urandom_range(0, 16)], 4'($urandom)), $urandom_range(0, 1), 0,
               AW'($urandom_range(0, 3)), -1);
    runInstr({IW{1'b1}}, 0, 0, 8'h00, -1);

    for (int i = 0; i < 40; i++) begin
      ensureRunning();
      ins = ($urandom_range(0, 15) == 0) ? {IW{1'b1}} : IW'($urandom);
      if ($urandom_range(0, 3) == 0) ins = mk(($urandom_range(0, 1) == 0) ? OP_LDR : OP_STR, 4'($urandom));
      ackAfter = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 4);
      runInstr(ins, $urandom_range(0, 2), ackAfter, AW'($urandom_range(0, 3)), -1);
    end

    ensureRunning();
    runInstr(mk(OP_LDR, 4'h9), 0, 10, 8'h00, 2);
    idleCycles(2);
    startRun();
    runInstr(mk(OP_ADD, 4'h1), 0, 0, 8'h00, -1);
    runInstr(mk(OP_STR, 4'h2), 0, 0, 8'h00, -1);

    @(posedge Clk);
    #1;
    nChecks++;
    if (sb.size() != 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
